// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and writeback datapath: load extension,
// source select, register-file write port and retired-instruction counter.
module writeback_stage #(
   parameter int DATA_W   = 32,
   parameter int RA_W     = 5,
   parameter int LINK_OFS = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall_w,
   input  logic              flush_w,
   input  logic              m_valid,
   input  logic              m_reg_we,
   input  logic [RA_W-1:0]   m_reg_addr,
   input  logic [2:0]        m_wb_sel,
   input  logic [2:0]        m_load_type,
   input  logic [1:0]        m_byte_ofs,
   input  logic [DATA_W-1:0] m_alu,
   input  logic [DATA_W-1:0] m_mem_rdata,
   input  logic [DATA_W-1:0] m_pc,
   input  logic [DATA_W-1:0] m_hi,
   input  logic [DATA_W-1:0] m_lo,
   input  logic [DATA_W-1:0] m_cp0,
   input  logic              cnt_clr,
   output logic              rf_we,
   output logic [RA_W-1:0]   rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              w_valid,
   output logic              w_misalign,
   output logic [31:0]       retire_cnt
);

   localparam logic [2:0] SEL_ALU  = 3'd0;
   localparam logic [2:0] SEL_MEM  = 3'd1;
   localparam logic [2:0] SEL_LINK = 3'd2;
   localparam logic [2:0] SEL_HI   = 3'd3;
   localparam logic [2:0] SEL_LO   = 3'd4;
   localparam logic [2:0] SEL_CP0  = 3'd5;

   localparam logic [2:0] LT_LB  = 3'd1;
   localparam logic [2:0] LT_LBU = 3'd2;
   localparam logic [2:0] LT_LH  = 3'd3;
   localparam logic [2:0] LT_LHU = 3'd4;

   localparam logic [DATA_W-1:0] LP_LINK = DATA_W'(LINK_OFS);

   logic              r_valid;
   logic              r_reg_we;
   logic [RA_W-1:0]   r_reg_addr;
   logic [2:0]        r_wb_sel;
   logic [2:0]        r_load_type;
   logic [1:0]        r_byte_ofs;
   logic [DATA_W-1:0] r_alu;
   logic [DATA_W-1:0] r_mem;
   logic [DATA_W-1:0] r_pc;
   logic [DATA_W-1:0] r_hi;
   logic [DATA_W-1:0] r_lo;
   logic [DATA_W-1:0] r_cp0;
   logic [31:0]       r_retire_cnt;

   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [DATA_W-1:0] w_load;
   logic              w_mis_raw;
   logic              w_retire;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid     <= 1'b0;
         r_reg_we    <= 1'b0;
         r_reg_addr  <= '0;
         r_wb_sel    <= '0;
         r_load_type <= '0;
         r_byte_ofs  <= '0;
         r_alu       <= '0;
         r_mem       <= '0;
         r_pc        <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_cp0       <= '0;
      end else if (flush_w) begin
         r_valid     <= 1'b0;
         r_reg_we    <= 1'b0;
         r_reg_addr  <= '0;
         r_wb_sel    <= '0;
         r_load_type <= '0;
         r_byte_ofs  <= '0;
         r_alu       <= '0;
         r_mem       <= '0;
         r_pc        <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_cp0       <= '0;
      end else if (!stall_w) begin
         r_valid     <= m_valid;
         r_reg_we    <= m_reg_we;
         r_reg_addr  <= m_reg_addr;
         r_wb_sel    <= m_wb_sel;
         r_load_type <= m_load_type;
         r_byte_ofs  <= m_byte_ofs;
         r_alu       <= m_alu;
         r_mem       <= m_mem_rdata;
         r_pc        <= m_pc;
         r_hi        <= m_hi;
         r_lo        <= m_lo;
         r_cp0       <= m_cp0;
      end
   end

   // Little-endian lane pick from the captured word
   always_comb begin
      w_byte = r_mem[7:0];
      case (r_byte_ofs)
         2'd1:    w_byte = r_mem[15:8];
         2'd2:    w_byte = r_mem[23:16];
         2'd3:    w_byte = r_mem[31:24];
         default: w_byte = r_mem[7:0];
      endcase
      w_half = r_byte_ofs[1] ? r_mem[31:16] : r_mem[15:0];
   end

   always_comb begin
      w_load    = r_mem;
      w_mis_raw = 1'b0;
      case (r_load_type)
         LT_LB:  w_load = {{(DATA_W-8){w_byte[7]}}, w_byte};
         LT_LBU: w_load = {{(DATA_W-8){1'b0}}, w_byte};
         LT_LH: begin
            w_load    = {{(DATA_W-16){w_half[15]}}, w_half};
            w_mis_raw = r_byte_ofs[0];
         end
         LT_LHU: begin
            w_load    = {{(DATA_W-16){1'b0}}, w_half};
            w_mis_raw = r_byte_ofs[0];
         end
         default: begin
            w_load    = r_mem;
            w_mis_raw = (r_byte_ofs != 2'd0);
         end
      endcase
   end

   always_comb begin
      rf_wdata = '0;
      case (r_wb_sel)
         SEL_ALU:  rf_wdata = r_alu;
         SEL_MEM:  rf_wdata = w_load;
         SEL_LINK: rf_wdata = r_pc + LP_LINK;
         SEL_HI:   rf_wdata = r_hi;
         SEL_LO:   rf_wdata = r_lo;
         SEL_CP0:  rf_wdata = r_cp0;
         default:  rf_wdata = '0;
      endcase
   end

   assign w_misalign = r_valid & (r_wb_sel == SEL_MEM) & w_mis_raw;
   assign rf_we      = r_valid & r_reg_we & (r_reg_addr != '0) & ~w_misalign;
   assign rf_waddr   = r_reg_addr;
   assign w_valid    = r_valid;

   // An instruction retires on the edge it leaves W
   assign w_retire = r_valid & ~stall_w & ~w_misalign;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_retire_cnt <= '0;
      else if (cnt_clr)
         r_retire_cnt <= '0;
      else if (w_retire)
         r_retire_cnt <= r_retire_cnt + 32'd1;
   end

   assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed scoreboard bench for writeback_stage.
module tb_writeback_stage;

   typedef struct packed {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        valid;
      logic        mis;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_w, flush_w, m_valid, m_reg_we, cnt_clr;
   logic [4:0]  m_reg_addr;
   logic [2:0]  m_wb_sel, m_load_type;
   logic [1:0]  m_byte_ofs;
   logic [31:0] m_alu, m_mem_rdata, m_pc, m_hi, m_lo, m_cp0;
   logic        rf_we, w_valid, w_misalign;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata, retire_cnt;

   exp_t        sb[$];
   exp_t        cur;
   logic [31:0] exp_cnt;
   int          ncmp = 0;
   int          nfail = 0;

   writeback_stage dut (
      .clk(clk), .reset(reset), .stall_w(stall_w), .flush_w(flush_w),
      .m_valid(m_valid), .m_reg_we(m_reg_we), .m_reg_addr(m_reg_addr),
      .m_wb_sel(m_wb_sel), .m_load_type(m_load_type),
      .m_byte_ofs(m_byte_ofs), .m_alu(m_alu), .m_mem_rdata(m_mem_rdata),
      .m_pc(m_pc), .m_hi(m_hi), .m_lo(m_lo), .m_cp0(m_cp0),
      .cnt_clr(cnt_clr), .rf_we(rf_we), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata), .w_valid(w_valid), .w_misalign(w_misalign),
      .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      ncmp++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic m(input logic v, input logic we, input logic [4:0] a,
                    input logic [2:0] sel, input logic [2:0] lt,
                    input logic [1:0] ofs, input logic [31:0] alu,
                    input logic [31:0] mem, input logic [31:0] pc);
      m_valid = v; m_reg_we = we; m_reg_addr = a; m_wb_sel = sel;
      m_load_type = lt; m_byte_ofs = ofs; m_alu = alu;
      m_mem_rdata = mem; m_pc = pc;
   endtask

   task automatic ex(input logic we, input logic [4:0] a,
                     input logic [31:0] d, input logic v, input logic mis);
      exp_t e;
      e.we = we; e.addr = a; e.data = d; e.valid = v; e.mis = mis;
      sb.push_back(e);
   endtask

   task automatic tick(input string nm, input logic st, input logic fl,
                       input logic clr);
      exp_t e;
      stall_w = st; flush_w = fl; cnt_clr = clr;
      if (clr)
         exp_cnt = 0;
      else if (cur.valid && !st && !cur.mis)
         exp_cnt = exp_cnt + 1;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         ncmp++;
         nfail++;
         $error("FAIL %s scoreboard empty observed=%h expected=entry",
                nm, rf_wdata);
      end else begin
         e = sb.pop_front();
         chk({nm, ".we"},    32'(rf_we),      32'(e.we));
         chk({nm, ".addr"},  32'(rf_waddr),   32'(e.addr));
         chk({nm, ".data"},  rf_wdata,        e.data);
         chk({nm, ".valid"}, 32'(w_valid),    32'(e.valid));
         chk({nm, ".mis"},   32'(w_misalign), 32'(e.mis));
         cur = e;
      end
      chk({nm, ".cnt"}, retire_cnt, exp_cnt);
      @(negedge clk);
      stall_w = 1'b0; flush_w = 1'b0; cnt_clr = 1'b0;
   endtask

   initial begin
      reset = 1'b1; stall_w = 1'b0; flush_w = 1'b0; cnt_clr = 1'b0;
      m(0, 0, 0, 0, 0, 0, 0, 0, 0);
      m_hi = 32'hAAAA_0001; m_lo = 32'h5555_0002; m_cp0 = 32'hC0C0_0003;
      cur = '0;
      exp_cnt = 0;
      repeat (2) @(negedge clk);
      chk("rst.we",    32'(rf_we),      0);
      chk("rst.addr",  32'(rf_waddr),   0);
      chk("rst.data",  rf_wdata,        0);
      chk("rst.valid", 32'(w_valid),    0);
      chk("rst.mis",   32'(w_misalign), 0);
      chk("rst.cnt",   retire_cnt,      0);
      reset = 1'b0;

      // byte loads
      m(1, 1, 3, 1, 1, 0, 0, 32'h80FF7F01, 0); ex(1, 3, 32'h00000001, 1, 0);
      tick("lb0", 0, 0, 0);
      m(1, 1, 3, 1, 1, 1, 0, 32'h80FF7F01, 0); ex(1, 3, 32'h0000007F, 1, 0);
      tick("lb1", 0, 0, 0);
      m(1, 1, 3, 1, 1, 2, 0, 32'h80FF7F01, 0); ex(1, 3, 32'hFFFFFFFF, 1, 0);
      tick("lb2", 0, 0, 0);
      m(1, 1, 3, 1, 1, 3, 0, 32'h80FF7F01, 0); ex(1, 3, 32'hFFFFFF80, 1, 0);
      tick("lb3", 0, 0, 0);
      m(1, 1, 4, 1, 2, 3, 0, 32'h80FF7F01, 0); ex(1, 4, 32'h00000080, 1, 0);
      tick("lbu3", 0, 0, 0);

      // half/word loads and misalignment
      m(1, 1, 6, 1, 3, 2, 0, 32'h8001F00F, 0); ex(1, 6, 32'hFFFF8001, 1, 0);
      tick("lh2", 0, 0, 0);
      m(1, 1, 6, 1, 4, 2, 0, 32'h8001F00F, 0); ex(1, 6, 32'h00008001, 1, 0);
      tick("lhu2", 0, 0, 0);
      m(1, 1, 6, 1, 4, 0, 0, 32'h8001F00F, 0); ex(1, 6, 32'h0000F00F, 1, 0);
      tick("lhu0", 0, 0, 0);
      m(1, 1, 6, 1, 3, 1, 0, 32'h8001F00F, 0); ex(0, 6, 32'hFFFFF00F, 1, 1);
      tick("lh1mis", 0, 0, 0);
      m(1, 1, 6, 1, 0, 0, 0, 32'h8001F00F, 0); ex(1, 6, 32'h8001F00F, 1, 0);
      tick("lw0", 0, 0, 0);
      m(1, 1, 6, 1, 0, 2, 0, 32'h8001F00F, 0); ex(0, 6, 32'h8001F00F, 1, 1);
      tick("lw2mis", 0, 0, 0);
      m(1, 1, 6, 0, 3, 1, 32'h77, 32'h8001F00F, 0); ex(1, 6, 32'h77, 1, 0);
      tick("alu_ofs1", 0, 0, 0);

      // link, $0, other sources
      m(1, 1, 31, 2, 0, 0, 0, 0, 32'hFFFFFFFC); ex(1, 31, 32'h4, 1, 0);
      tick("link_wrap", 0, 0, 0);
      m(1, 1, 0, 0, 0, 0, 32'h99, 0, 0); ex(0, 0, 32'h99, 1, 0);
      tick("r0", 0, 0, 0);
      m(1, 1, 8, 3, 0, 0, 0, 0, 0); ex(1, 8, 32'hAAAA0001, 1, 0);
      tick("hi", 0, 0, 0);
      m(1, 1, 9, 4, 0, 0, 0, 0, 0); ex(1, 9, 32'h55550002, 1, 0);
      tick("lo", 0, 0, 0);
      m(1, 1, 10, 5, 0, 0, 0, 0, 0); ex(1, 10, 32'hC0C00003, 1, 0);
      tick("cp0", 0, 0, 0);
      m(1, 1, 11, 6, 0, 0, 32'h55, 0, 0); ex(1, 11, 32'h0, 1, 0);
      tick("rsv6", 0, 0, 0);
      m(0, 1, 12, 0, 0, 0, 32'h66, 0, 0); ex(0, 12, 32'h66, 0, 0);
      tick("invalid", 0, 0, 0);

      // stall holds the captured write
      m(1, 1, 5, 0, 0, 0, 32'h1234, 0, 0); ex(1, 5, 32'h1234, 1, 0);
      tick("cap", 0, 0, 0);
      m(1, 1, 7, 0, 0, 0, 32'hDEAD, 0, 0);
      for (int i = 0; i < 3; i++) begin
         ex(1, 5, 32'h1234, 1, 0);
         tick("stall", 1, 0, 0);
      end
      ex(1, 7, 32'hDEAD, 1, 0);
      tick("unstall", 0, 0, 0);

      // flush beats stall, flush alone
      m(1, 1, 13, 0, 0, 0, 32'hBEEF, 0, 0); ex(0, 0, 0, 0, 0);
      tick("stflush", 1, 1, 0);
      ex(0, 0, 0, 0, 0);
      tick("flush", 0, 1, 0);

      // counter wrap
      ex(1, 13, 32'hBEEF, 1, 0);
      tick("pre", 0, 0, 0);
      force dut.r_retire_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.r_retire_cnt;
      exp_cnt = 32'hFFFF_FFFE;
      chk("preload", retire_cnt, exp_cnt);
      ex(1, 13, 32'hBEEF, 1, 0);
      tick("wrap1", 0, 0, 0);
      ex(1, 13, 32'hBEEF, 1, 0);
      tick("wrap2", 0, 0, 0);
      ex(1, 13, 32'hBEEF, 1, 0);
      tick("inc", 0, 0, 0);
      ex(1, 13, 32'hBEEF, 1, 0);
      tick("clr", 0, 0, 1);
      ex(1, 13, 32'hBEEF, 1, 0);
      tick("postclr", 0, 0, 0);

      // async reset while W holds a valid write
      #2;
      reset = 1'b1;
      #1;
      chk("arst.we",    32'(rf_we),   0);
      chk("arst.valid", 32'(w_valid), 0);
      chk("arst.data",  rf_wdata,     0);
      chk("arst.cnt",   retire_cnt,   0);
      #1;
      reset = 1'b0;
      cur = '0;
      exp_cnt = 0;
      m(1, 1, 14, 0, 0, 0, 32'h4321, 0, 0); ex(1, 14, 32'h4321, 1, 0);
      tick("afterrst", 0, 0, 0);
      ex(1, 14, 32'h4321, 1, 0);
      tick("afterrst2", 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
